// File: rtl/ysyx_24100006_ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one instruction-memory read in flight,
// and hands {inst, pc, pc+4} to IF_ID over a valid/ready handshake, squashing stale responses.
module ysyx_24100006_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_add_4
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        drop_q, drop_d;

    logic [31:0] redirect_pc_aligned;
    assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            drop_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;

        if (redirect_valid) begin
            // A redirect wins over everything; an in-flight request must have its response squashed.
            pc_d = redirect_pc_aligned;
            unique case (state_q)
                S_IDLE, S_HOLD: state_d = S_REQ;
                S_REQ: begin
                    if (mem_req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (mem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_d  = mem_resp_data;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decode registered state only.
    assign mem_req_valid = (state_q == S_REQ);
    assign out_valid     = (state_q == S_HOLD);
    assign mem_req_addr  = pc_q;
    assign out_inst      = inst_q;
    assign out_pc        = pc_q;
    assign out_pc_add_4  = pc_q + 32'd4;

endmodule

// File: tb/tb_ysyx_24100006_ifu_fetch.sv
// Bench for the fetch stage: a behavioural memory answering addr^0000_FFFF and an
// architectural PC model checked every cycle, plus directed scenarios with literal expectations.
module tb_ysyx_24100006_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam logic [31:0] MEM_KEY  = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_add_4;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    // Architectural model: the PC the stage must currently be presenting / fetching.
    logic [31:0] ref_pc   = RESET_PC;
    bit          model_on = 1'b0;

    // What the upcoming edge will see, recorded away from the edge.
    bit          edge_rst  = 1'b0;
    bit          edge_fire = 1'b0;
    logic [31:0] edge_addr = 32'h0;

    // Memory model state.
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;

    always #5 clk = ~clk;

    ysyx_24100006_ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pc_add_4   (out_pc_add_4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Compare DUT against the model, then advance the model using this cycle's inputs.
    task automatic model_compare();
        if (model_on) begin
            check("m_req_addr", mem_req_addr, ref_pc);
            check("m_out_pc", out_pc, ref_pc);
            check("m_pc_add_4", out_pc_add_4, ref_pc + 32'd4);
            check("m_exclusive", 32'(out_valid & mem_req_valid), 0);
            if (out_valid) check("m_out_inst", out_inst, ref_pc ^ MEM_KEY);
            if (mem_req_valid) check("m_one_outstanding", 32'(mem_busy), 0);
        end
        edge_rst  = !reset;
        edge_fire = reset && mem_req_valid && mem_req_ready;
        edge_addr = mem_req_addr;
        if (!reset) begin
            ref_pc   = RESET_PC;
            model_on = 1'b1;
        end else if (redirect_valid) begin
            ref_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (out_valid && out_ready) begin
            ref_pc = ref_pc + 32'd4;
        end
    endtask

    task automatic mem_step();
        if (edge_rst) begin
            mem_busy       = 1'b0;
            mem_resp_valid = 1'b0;
        end else begin
            if (mem_resp_valid) begin
                mem_resp_valid = 1'b0;
                mem_busy       = 1'b0;
            end
            if (edge_fire) begin
                mem_busy = 1'b1;
                mem_addr = edge_addr;
                mem_cnt  = mem_lat;
            end
            if (mem_busy && !mem_resp_valid) begin
                mem_cnt--;
                if (mem_cnt == 0) mem_resp_valid = 1'b1;
            end
        end
        mem_resp_data = mem_resp_valid ? (mem_addr ^ MEM_KEY) : 32'hDEAD_BEEF;
    endtask

    task automatic tick();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        #1;
        mem_step();
        cyc++;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) check({name, "_timeout"}, 32'(out_valid), 1);
    endtask

    task automatic redirect_tick(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int n;
        int c1;
        int c2;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'hDEAD_BEEF;
        out_ready      = 1'b1;

        // Reset held three cycles.
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_req_valid", 32'(mem_req_valid), 0);
        check("rst_out_inst", out_inst, 32'h0000_0013);
        check("rst_out_pc", out_pc, 32'h3000_0000);
        check("rst_pc_add_4", out_pc_add_4, 32'h3000_0004);
        reset = 1'b1;
        check("idle_req_valid", 32'(mem_req_valid), 0);
        tick();
        check("first_req_valid", 32'(mem_req_valid), 1);
        check("first_req_addr", mem_req_addr, 32'h3000_0000);

        // Straight-line fetch, one-cycle memory.
        wait_valid("line0", n);
        c1 = cyc;
        check("line0_lat", 32'(n), 2);
        check("line0_pc", out_pc, 32'h3000_0000);
        check("line0_inst", out_inst, 32'h3000_FFFF);
        check("line0_add4", out_pc_add_4, 32'h3000_0004);
        tick();
        wait_valid("line1", n);
        c2 = cyc;
        check("line_period", 32'(c2 - c1), 3);
        check("line1_pc", out_pc, 32'h3000_0004);
        check("line1_inst", out_inst, 32'h3000_FFFB);
        tick();
        wait_valid("line2", n);
        check("line2_pc", out_pc, 32'h3000_0008);
        check("line2_inst", out_inst, 32'h3000_FFF7);
        check("line2_add4", out_pc_add_4, 32'h3000_000C);

        // Backpressure in HOLD.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(out_valid), 1);
            check("bp_pc", out_pc, 32'h3000_0008);
            check("bp_inst", out_inst, 32'h3000_FFF7);
            check("bp_no_req", 32'(mem_req_valid), 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_req", 32'(mem_req_valid), 1);
        check("bp_next_addr", mem_req_addr, 32'h3000_000C);

        // Redirect while waiting on a slow response.
        mem_lat = 3;
        tick();
        redirect_tick(32'h8000_0102);
        mem_lat = 1;
        check("rw_still_wait", 32'(mem_req_valid), 0);
        check("rw_addr", mem_req_addr, 32'h8000_0100);
        wait_valid("rw", n);
        check("rw_lat", 32'(n), 4);
        check("rw_pc", out_pc, 32'h8000_0100);
        check("rw_inst", out_inst, 32'h8000_FEFF);

        // Redirect in HOLD with out_ready high the same cycle.
        redirect_tick(32'h8000_0203);
        check("rh_no_valid", 32'(out_valid), 0);
        check("rh_req_valid", 32'(mem_req_valid), 1);
        check("rh_addr", mem_req_addr, 32'h8000_0200);
        wait_valid("rh", n);
        check("rh_pc", out_pc, 32'h8000_0200);
        check("rh_inst", out_inst, 32'h8000_FDFF);

        // Redirect in REQ while memory accepts: the accepted request's response must be dropped.
        tick();
        redirect_tick(32'h9000_0000);
        check("rq_in_wait", 32'(mem_req_valid), 0);
        wait_valid("rq", n);
        check("rq_lat", 32'(n), 3);
        check("rq_pc", out_pc, 32'h9000_0000);
        check("rq_inst", out_inst, 32'h9000_FFFF);

        // Redirect in REQ while memory stalls: address changes, no request lost.
        tick();
        mem_req_ready = 1'b0;
        redirect_tick(32'hA000_0010);
        check("rs_req_valid", 32'(mem_req_valid), 1);
        check("rs_addr", mem_req_addr, 32'hA000_0010);
        tick();
        check("rs_stall_addr", mem_req_addr, 32'hA000_0010);
        mem_req_ready = 1'b1;
        wait_valid("rs", n);
        check("rs_pc", out_pc, 32'hA000_0010);
        check("rs_inst", out_inst, 32'hA000_FFEF);

        // Reset while a request is outstanding.
        tick();
        mem_lat = 3;
        tick();
        reset = 1'b0;
        tick();
        reset   = 1'b1;
        mem_lat = 1;
        check("mr_valid", 32'(out_valid), 0);
        check("mr_req_valid", 32'(mem_req_valid), 0);
        check("mr_addr", mem_req_addr, 32'h3000_0000);
        check("mr_inst", out_inst, 32'h0000_0013);
        wait_valid("mr", n);
        check("mr_lat", 32'(n), 3);
        check("mr_pc", out_pc, 32'h3000_0000);
        check("mr_inst_new", out_inst, 32'h3000_FFFF);

        // Redirect in WAIT with the response arriving the same cycle.
        tick();
        tick();
        redirect_tick(32'hB000_0000);
        check("rr_req_valid", 32'(mem_req_valid), 1);
        check("rr_addr", mem_req_addr, 32'hB000_0000);
        wait_valid("rr", n);
        check("rr_lat", 32'(n), 2);
        check("rr_pc", out_pc, 32'hB000_0000);
        check("rr_inst", out_inst, 32'hB000_FFFF);

        // PC wrap at the top of the address space.
        redirect_tick(32'hFFFF_FFFF);
        check("wrap_addr", mem_req_addr, 32'hFFFF_FFFC);
        check("wrap_add4", out_pc_add_4, 32'h0000_0000);
        wait_valid("wrap", n);
        check("wrap_inst", out_inst, 32'hFFFF_0003);
        tick();
        check("wrap_next_req", 32'(mem_req_valid), 1);
        check("wrap_next_addr", mem_req_addr, 32'h0000_0000);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
